// File: rtl/pattern_count_engine.sv
// rtl/pattern_count_engine.sv - counts 5-bit pattern hits over a byte string in data memory
// Shares the data-memory port with the core via req/gnt; results are written back to memory.
module pattern_count_engine #(
    parameter int N_BYTES  = 32,
    parameter int AW       = 8,
    parameter int PAT_ADDR = 32,
    parameter int CTB_ADDR = 33,
    parameter int CTO_ADDR = 34,
    parameter int CTS_ADDR = 35
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic          busy,
    output logic          mem_req,
    input  logic          mem_gnt,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LDPAT = 3'd1,
        SCAN  = 3'd2,
        WCTB  = 3'd3,
        WCTO  = 3'd4,
        WCTS  = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t        state;
    logic [4:0]    pat;
    logic [7:0]    prev;
    logic [AW-1:0] idx;
    logic [7:0]    ctb;
    logic [7:0]    cto;
    logic [7:0]    cts;

    logic [2:0]    in_hits;
    logic [2:0]    cross_hits;
    logic [7:0]    cross_bits;
    logic          active;

    // Crossing windows all live in {prev[3:0], b[7:4]}, sliding the same way as in-byte windows.
    always_comb begin
        in_hits    = 3'd0;
        cross_hits = 3'd0;
        cross_bits = {prev[3:0], mem_rd_data[7:4]};
        for (int k = 0; k < 4; k++) begin
            in_hits    = in_hits + 3'(mem_rd_data[k +: 5] == pat);
            cross_hits = cross_hits + 3'(cross_bits[k +: 5] == pat);
        end
        if (idx == '0) begin
            cross_hits = 3'd0;
        end
    end

    assign active = (state != IDLE) && (state != DONE);

    always_comb begin
        mem_req     = active;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
        case (state)
            LDPAT: mem_addr = AW'(PAT_ADDR);
            SCAN:  mem_addr = idx;
            WCTB: begin
                mem_addr    = AW'(CTB_ADDR);
                mem_wr_en   = mem_gnt;
                mem_wr_data = ctb;
            end
            WCTO: begin
                mem_addr    = AW'(CTO_ADDR);
                mem_wr_en   = mem_gnt;
                mem_wr_data = cto;
            end
            WCTS: begin
                mem_addr    = AW'(CTS_ADDR);
                mem_wr_en   = mem_gnt;
                mem_wr_data = cts;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pat   <= 5'd0;
            prev  <= 8'd0;
            idx   <= '0;
            ctb   <= 8'd0;
            cto   <= 8'd0;
            cts   <= 8'd0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ctb   <= 8'd0;
                        cto   <= 8'd0;
                        cts   <= 8'd0;
                        idx   <= '0;
                        prev  <= 8'd0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= LDPAT;
                    end
                end
                LDPAT: begin
                    if (mem_gnt) begin
                        pat   <= mem_rd_data[7:3];
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (mem_gnt) begin
                        ctb  <= ctb + {5'd0, in_hits};
                        cto  <= cto + {7'd0, (in_hits != 3'd0)};
                        cts  <= cts + {5'd0, in_hits} + {5'd0, cross_hits};
                        prev <= mem_rd_data;
                        idx  <= idx + 1'b1;
                        if (idx == AW'(N_BYTES - 1)) begin
                            state <= WCTB;
                        end
                    end
                end
                WCTB: if (mem_gnt) state <= WCTO;
                WCTO: if (mem_gnt) state <= WCTS;
                WCTS: begin
                    if (mem_gnt) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
